// File: rtl/alu_sequencer.sv
// Issue/writeback controller for the 8-bit ALU: owns an 8x8 register file,
// launches one instruction per 3 cycles and commits result and flags.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [2:0] instr_rd,
    input  logic [2:0] instr_rs,
    input  logic [2:0] instr_rt,
    input  logic       instr_use_imm,
    input  logic [7:0] instr_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_opcode,
    input  logic [7:0] alu_y,
    input  logic       alu_cout,
    input  logic       alu_bout,
    output logic       done,
    output logic       flag_c,
    output logic       flag_b,
    output logic       flag_z,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       accept, host_we;
    logic       done_q, done_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [3:0] op_q, op_d;
    logic [2:0] rd_q, rd_d;
    logic       flag_c_q, flag_c_d;
    logic       flag_b_q, flag_b_d;
    logic       flag_z_q, flag_z_d;
    logic [7:0] regs_q [8];
    logic [7:0] regs_d [8];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == S_IDLE) && !rst;
        done_d      = (state_q == S_EXEC);
    end

    assign accept  = instr_valid & instr_ready;
    assign host_we = wr_en & instr_ready;

    always_comb begin
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        op_d     = op_q;
        rd_d     = rd_q;
        flag_c_d = flag_c_q;
        flag_b_d = flag_b_q;
        flag_z_d = flag_z_q;
        for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
        // Operands are read from regs_q, so a same-cycle host write is not seen
        if (accept) begin
            alu_a_d = regs_q[instr_rs];
            alu_b_d = instr_use_imm ? instr_imm : regs_q[instr_rt];
            op_d    = instr_op;
            rd_d    = instr_rd;
        end
        if (host_we) regs_d[wr_addr] = wr_data;
        if (state_q == S_EXEC) begin
            regs_d[rd_q] = alu_y;
            flag_z_d     = (alu_y == 8'h00);
            // ALU merges carry/borrow sources; only arithmetic ops may update them
            if (op_q == 4'd0 || op_q == 4'd2) flag_c_d = alu_cout;
            if (op_q == 4'd1 || op_q == 4'd3) flag_b_d = alu_bout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q   <= 1'b0;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            op_q     <= 4'h0;
            rd_q     <= 3'd0;
            flag_c_q <= 1'b0;
            flag_b_q <= 1'b0;
            flag_z_q <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
        end else begin
            done_q   <= done_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            flag_c_q <= flag_c_d;
            flag_b_q <= flag_b_d;
            flag_z_q <= flag_z_d;
            for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = op_q;
    assign done       = done_q;
    assign flag_c     = flag_c_q;
    assign flag_b     = flag_b_q;
    assign flag_z     = flag_z_q;
    assign rd_data    = regs_q[rd_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural alu8 model closing the loop.
// Directed vector table plus handshake, same-cycle write and reset sequences.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [2:0] instr_rd, instr_rs, instr_rt;
    logic       instr_use_imm;
    logic [7:0] instr_imm;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_y;
    logic       alu_cout, alu_bout;
    logic       done;
    logic       flag_c, flag_b, flag_z;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs(instr_rs), .instr_rt(instr_rt),
        .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_bout(alu_bout),
        .done(done),
        .flag_c(flag_c), .flag_b(flag_b), .flag_z(flag_z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // alu8 model: carries/borrows are merged across sources regardless of op
    logic [15:0] aa;
    logic [2:0]  sh;
    always_comb begin
        aa = {alu_a, alu_a};
        sh = alu_b[2:0];
        alu_y = 8'h00;
        case (alu_opcode)
            4'd0:  alu_y = alu_a + alu_b;
            4'd1:  alu_y = alu_a - alu_b;
            4'd2:  alu_y = alu_a + 8'd1;
            4'd3:  alu_y = alu_a - 8'd1;
            4'd4:  alu_y = alu_a & alu_b;
            4'd5:  alu_y = alu_a | alu_b;
            4'd6:  alu_y = alu_a ^ alu_b;
            4'd7:  alu_y = ~alu_a;
            4'd8:  alu_y = ~(alu_a & alu_b);
            4'd9:  alu_y = ~(alu_a | alu_b);
            4'd10: alu_y = ~(alu_a ^ alu_b);
            4'd11: alu_y = alu_a << sh;
            4'd12: alu_y = alu_a >> sh;
            4'd13: alu_y = $signed(alu_a) >>> sh;
            4'd14: begin aa = aa << sh; alu_y = aa[15:8]; end
            default: begin aa = aa >> sh; alu_y = aa[7:0]; end
        endcase
        alu_cout = (({1'b0, alu_a} + {1'b0, alu_b}) > 9'h0FF) || (alu_a == 8'hFF);
        alu_bout = (alu_a < alu_b) || (alu_a == 8'h00);
    end

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       use_imm;
        logic [7:0] imm;
        logic [7:0] y;
        logic       c;
        logic       b;
        logic       z;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic issue(input vec_t v, input int idx);
        check($sformatf("v%0d ready_pre", idx), instr_ready, 1);
        instr_valid = 1'b1; instr_op = v.op; instr_rd = v.rd;
        instr_rs = v.rs; instr_rt = v.rt;
        instr_use_imm = v.use_imm; instr_imm = v.imm;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        check($sformatf("v%0d ready_n1", idx), instr_ready, 0);
        check($sformatf("v%0d done_n1", idx), done, 0);
        check($sformatf("v%0d opcode", idx), alu_opcode, v.op);
        if (v.use_imm) check($sformatf("v%0d alu_b", idx), alu_b, v.imm);
        @(posedge clk); @(negedge clk);
        check($sformatf("v%0d done_n2", idx), done, 1);
        check($sformatf("v%0d ready_n2", idx), instr_ready, 0);
        rd_addr = v.rd; #1;
        check($sformatf("v%0d result", idx), rd_data, v.y);
        check($sformatf("v%0d flags", idx), {flag_c, flag_b, flag_z},
              {v.c, v.b, v.z});
        @(posedge clk); @(negedge clk);
        check($sformatf("v%0d done_n3", idx), done, 0);
        check($sformatf("v%0d ready_n3", idx), instr_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            op    rd    rs    rt    imm?  imm     y      c     b     z
        vecs[0]  = '{4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'd1, 3'd4, 3'd1, 3'd0, 1'b1, 8'h07, 8'hFE, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{4'd4, 3'd5, 3'd4, 3'd0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{4'd14,3'd6, 3'd1, 3'd0, 1'b1, 8'h01, 8'h03, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{4'd11,3'd7, 3'd1, 3'd0, 1'b1, 8'h08, 8'h81, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{4'd1, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{4'd0, 3'd0, 3'd2, 3'd0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'd6, 3'd5, 3'd1, 3'd0, 1'b1, 8'hFF, 8'h7E, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'd3, 3'd3, 3'd2, 3'd0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{4'd2, 3'd4, 3'd3, 3'd0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{4'd5, 3'd6, 3'd0, 3'd5, 1'b0, 8'h00, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{4'd15,3'd7, 3'd1, 3'd0, 1'b1, 8'h01, 8'hC0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{4'd13,3'd2, 3'd1, 3'd0, 1'b1, 8'h03, 8'hF0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{4'd12,3'd0, 3'd1, 3'd0, 1'b1, 8'h03, 8'h10, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{4'd7, 3'd1, 3'd1, 3'd0, 1'b1, 8'h00, 8'h7E, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{4'd9, 3'd5, 3'd0, 3'd4, 1'b0, 8'h00, 8'hEF, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; instr_valid = 1'b0; instr_op = 4'd0;
        instr_rd = 3'd0; instr_rs = 3'd0; instr_rt = 3'd0;
        instr_use_imm = 1'b0; instr_imm = 8'h00;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00; rd_addr = 3'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready", instr_ready, 0);
        check("rst done", done, 0);
        check("rst flags", {flag_c, flag_b, flag_z}, 0);
        check("rst alu", {alu_a, alu_b, alu_opcode}, 0);
        check("rst r0", rd_data, 8'h00);
        rst = 1'b0; #1;
        check("post-rst ready", instr_ready, 1);

        host_wr(3'd1, 8'hF0);
        host_wr(3'd2, 8'h20);
        for (int i = 0; i < 16; i++) begin
            if (i == 1) host_wr(3'd1, 8'h05);
            if (i == 3) host_wr(3'd1, 8'h81);
            issue(vecs[i], i);
        end

        // Back-to-back INC r1 with valid held high; host writes while busy
        instr_valid = 1'b1; instr_op = 4'd2; instr_rd = 3'd1;
        instr_rs = 3'd1; instr_rt = 3'd0; instr_use_imm = 1'b1;
        instr_imm = 8'h00; wr_addr = 3'd7; wr_data = 8'hAA;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("b2b ready k%0d", k), instr_ready, (k % 3) == 0);
            check($sformatf("b2b done k%0d", k), done, (k % 3) == 2);
            wr_en = ~instr_ready;
            @(posedge clk); @(negedge clk);
        end
        instr_valid = 1'b0; wr_en = 1'b0;
        check("b2b ready end", instr_ready, 1);
        check("b2b done end", done, 0);
        rd_addr = 3'd1; #1;
        check("b2b r1", rd_data, 8'h81);
        rd_addr = 3'd7; #1;
        check("b2b r7 dropped", rd_data, 8'hC0);
        check("b2b flag_c", flag_c, 0);

        // Same-cycle host write and accept
        host_wr(3'd1, 8'h10);
        instr_valid = 1'b1; instr_op = 4'd2; instr_rd = 3'd1;
        instr_rs = 3'd1; instr_use_imm = 1'b1; instr_imm = 8'h00;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h55;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0; wr_en = 1'b0; rd_addr = 3'd1; #1;
        check("sc r1 mid", rd_data, 8'h55);
        check("sc alu_a", alu_a, 8'h10);
        @(posedge clk); @(negedge clk);
        check("sc r1 wb", rd_data, 8'h11);
        check("sc done", done, 1);
        @(posedge clk); @(negedge clk);

        // Reset during EXEC
        instr_valid = 1'b1; instr_op = 4'd0; instr_rd = 3'd3;
        instr_rs = 3'd1; instr_rt = 3'd1; instr_use_imm = 1'b0;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0; rst = 1'b1; #1;
        check("rx ready in rst", instr_ready, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; #1;
        check("rx ready", instr_ready, 1);
        check("rx done", done, 0);
        check("rx flags", {flag_c, flag_b, flag_z}, 0);
        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r); #1;
            check($sformatf("rx r%0d", r), rd_data, 8'h00);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("rx no done k%0d", k), done, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue/writeback controller that drives the 8-bit ALU (`alu8`) as its initiator. It accepts one register-to-register or register-immediate instruction per valid/ready handshake and reads operands from an internal 8×8 register file. It presents opcode and operands to the ALU, then captures the result into the destination register and updates the carry, borrow and zero flags. It sits between the Mega-8 decode stage and the combinational ALU.

## Interface
- No parameters. Fixed: 8 registers × 8 bits, 4-bit opcode matching the ALU encoding (0 ADD, 1 SUB, 2 INC, 3 DEC, 4–10 logic, 11–15 shift/rotate).
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr_op  in  4  ALU opcode
- instr_rd  in  3  destination register
- instr_rs  in  3  operand A register
- instr_rt  in  3  operand B register (ignored when instr_use_imm=1)
- instr_use_imm  in  1  operand B taken from instr_imm
- instr_imm  in  8  immediate operand B
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_opcode  out  4  registered opcode to ALU
- alu_y  in  8  ALU result
- alu_cout  in  1  ALU carry out
- alu_bout  in  1  ALU borrow out
- done  out  1  one-cycle pulse: writeback completed
- flag_c, flag_b, flag_z  out  1 each  carry, borrow, zero flags
- wr_en  in  1  host register write
- wr_addr  in  3  host write address
- wr_data  in  8  host write data
- rd_addr  in  3  debug read address
- rd_data  out  8  combinational read of reg[rd_addr]

## Operation
- FSM states: IDLE → EXEC → DONE → IDLE. No other transitions except reset.
- instr_ready = 1 only in IDLE (and not rst). Accept = instr_valid & instr_ready.
- IDLE on accept: register alu_a ← reg[rs]; alu_b ← use_imm ? imm : reg[rt]; alu_opcode ← op; latch rd. Go to EXEC. Without accept: stay; ALU outputs hold their previous values.
- EXEC: ALU inputs are stable. At the clock edge: reg[rd] ← alu_y; flag_z ← (alu_y == 0). Go to DONE.
- Flag masking: the ALU ORs its adder/incrementer carries and its subtractor/decrementer borrows regardless of opcode. The controller therefore updates flag_c ← alu_cout only for op 0 and 2, and flag_b ← alu_bout only for op 1 and 3. For all other ops both flags hold.
- DONE: done = 1 for this cycle only. Go to IDLE.
- Host write: honored only when instr_ready = 1. reg[wr_addr] ← wr_data. Ignored in EXEC and DONE; no queuing.
- Host write in the same cycle as an accept: operand reads see the pre-write value, and the write still occurs.
- rd == rs or rd == rt is legal. Operands are captured at accept, so they are unaffected.
- rd_data reflects register contents after the most recent edge, including writeback.

## Timing
- Accept at edge N. ALU inputs are valid during cycle N+1. reg[rd] and flags are updated at edge N+2. done is high in cycle N+2. instr_ready returns high in cycle N+3.
- Throughput: one instruction per 3 cycles.
- instr_* must remain stable while instr_valid=1 and instr_ready=0.
- Reset (any state, including mid-operation): state → IDLE; all 8 registers, alu_a, alu_b, alu_opcode and all flags → 0; done → 0. A pending instruction is abandoned with no writeback. instr_ready is 0 during the rst cycle and 1 on the first cycle after.
- All outputs except rd_data and instr_ready are registered.

## Test plan
- ADD: host writes R1=0xF0, R2=0x20. Issue op0 rd=R3 rs=R1 rt=R2. Required: R3=0x10, flag_c=1, flag_z=0, done exactly at accept+2, ready low for cycles accept+1 and accept+2.
- SUB with immediate: R1=0x05. Issue op1 rd=R4 rs=R1 imm=0x07. Required: R4=0xFE, flag_b=1. Then issue op4 (AND) with R4 & imm 0x01. Required: R5=0x00, flag_z=1, flag_b stays 1, flag_c unchanged.
- Shift/rotate: R1=0x81. Issue op14 (ROL) with imm=1. Required: result 0x03, flag_c/flag_b held. Then op11 (SLL) with imm=8. The ALU uses b[2:0]=0, so the required result is 0x81.
- Handshake: hold instr_valid high with back-to-back instructions. Required: accepts exactly every 3 cycles, and each done pulse is exactly 1 cycle wide. Host writes issued during EXEC/DONE are dropped, as confirmed via rd_data.
- Same-cycle host write and accept: R1=0x10, then wr R1=0x55 in the accept cycle of op2 (INC) rd=R1 rs=R1. Required: R1 holds 0x55 for one cycle, then 0x11 after writeback.
- Reset during EXEC: assert rst for one cycle. Required: no writeback, every register reads 0 via rd_data, all flags are 0, done never pulses, and instr_ready is 1 on the cycle after rst deasserts.
